// File: rtl/i2c_apb_pkg.sv
// Shared definitions for the I2C master APB register interface:
// requester FSM states and the register address map.
package i2c_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam logic [7:0] TRANSMIT   = 8'h00;
    localparam logic [7:0] RX_DATA    = 8'h01;
    localparam logic [7:0] STATUS     = 8'h02;
    localparam logic [7:0] SLAVE_ADDR = 8'h03;
    localparam logic [7:0] COMMAND    = 8'h04;
    localparam logic [7:0] PRESCALE   = 8'h05;

endpackage

// File: rtl/apb_master_interface.sv
// APB requester: turns one valid/ready command into one SETUP->ACCESS transfer
// and returns a single-cycle response, with a bounded number of wait states.
module apb_master_interface
    import i2c_apb_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk_i,
    input  logic                  preset_ni,
    input  logic                  cmd_valid_i,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  cmd_ready_o,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_timeout_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic                  pwrite_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Count value whose increment would reach the limit: abort on that edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_state_e       state;
    logic [CNT_W-1:0] wait_cnt;

    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = psel_o;

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            paddr_o       <= '0;
            pwrite_o      <= 1'b0;
            pwdata_o      <= '0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_timeout_o <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        paddr_o  <= cmd_addr_i;
                        pwrite_o <= cmd_write_i;
                        if (cmd_write_i) begin
                            pwdata_o <= cmd_wdata_i;
                        end
                        psel_o   <= 1'b1;
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i) begin
                        rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
                        rsp_timeout_o <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        state         <= IDLE;
                    end else if ((TIMEOUT_CYCLES > 0) && (wait_cnt == CNT_LAST)) begin
                        wait_cnt      <= wait_cnt + CNT_W'(1);
                        rsp_rdata_o   <= '0;
                        rsp_timeout_o <= 1'b1;
                        rsp_valid_o   <= 1'b1;
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        state         <= IDLE;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    psel_o    <= 1'b0;
                    penable_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_interface.sv
// Directed bench for apb_master_interface: latency, wait states, timeout,
// queued commands and asynchronous reset during a transfer.
module tb_apb_master_interface;
    import i2c_apb_pkg::*;

    logic       pclk;
    logic       preset_n;
    logic       cmd_valid;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;
    logic       busy;
    logic [7:0] paddr;
    logic       pwrite;
    logic       psel;
    logic       penable;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       tie_psel;
    logic       pready_man;

    int checks = 0;
    int passes = 0;

    assign pready = tie_psel ? psel : pready_man;

    apb_master_interface #(
        .DATA_WIDTH    (8),
        .ADDR_WIDTH    (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk_i       (pclk),
        .preset_ni    (preset_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_write_i  (cmd_write),
        .cmd_addr_i   (cmd_addr),
        .cmd_wdata_i  (cmd_wdata),
        .cmd_ready_o  (cmd_ready),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_timeout_o(rsp_timeout),
        .busy_o       (busy),
        .paddr_o      (paddr),
        .pwrite_o     (pwrite),
        .psel_o       (psel),
        .penable_o    (penable),
        .pwdata_o     (pwdata),
        .prdata_i     (prdata),
        .pready_i     (pready)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Presents a command in IDLE and returns #1 after the accept edge (cycle N+1).
    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++;
        if ({cmd_ready, busy, psel, penable, pwrite, rsp_valid, rsp_timeout, rsp_rdata, paddr, pwdata} !== {7'b1000000, 24'h0}) begin
            $display("FAIL reset_state: got ready=%b busy=%b psel=%b pen=%b pwr=%b rv=%b rto=%b rdata=%h paddr=%h pwdata=%h, need ready=1 and all else 0",
                     cmd_ready, busy, psel, penable, pwrite, rsp_valid, rsp_timeout, rsp_rdata, paddr, pwdata);
        end else passes++;
        preset_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        tie_psel = 1'b1;
        send_cmd(1'b1, PRESCALE, 8'h1F);
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, busy, cmd_ready} !== {3'b101, 8'h05, 8'h1F, 2'b10}) begin
            $display("FAIL write_setup: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h busy=%b ready=%b, need 1 0 1 05 1f 1 0",
                     psel, penable, pwrite, paddr, pwdata, busy, cmd_ready);
        end else passes++;
        step();
        checks++;
        if ({psel, penable, rsp_valid, paddr, pwdata} !== {3'b110, 8'h05, 8'h1F}) begin
            $display("FAIL write_access: got psel=%b pen=%b rv=%b paddr=%h pwdata=%h, need 1 1 0 05 1f",
                     psel, penable, rsp_valid, paddr, pwdata);
        end else passes++;
        step();
        checks++;
        if ({rsp_valid, rsp_timeout, rsp_rdata, psel, penable, cmd_ready} !== {2'b10, 8'h00, 3'b001}) begin
            $display("FAIL write_rsp: got rv=%b rto=%b rdata=%h psel=%b pen=%b ready=%b, need 1 0 00 0 0 1",
                     rsp_valid, rsp_timeout, rsp_rdata, psel, penable, cmd_ready);
        end else passes++;
        step();
        checks++;
        if ({rsp_valid, paddr, pwrite} !== {1'b0, 8'h05, 1'b1}) begin
            $display("FAIL write_pulse_hold: got rv=%b paddr=%h pwr=%b, need 0 05 1", rsp_valid, paddr, pwrite);
        end else passes++;
    endtask

    task automatic test_read();
        tie_psel = 1'b1;
        prdata   = 8'hA5;
        send_cmd(1'b0, STATUS, 8'h77);
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata} !== {3'b100, 8'h02, 8'h1F}) begin
            $display("FAIL read_setup: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h, need 1 0 0 02 1f",
                     psel, penable, pwrite, paddr, pwdata);
        end else passes++;
        step();
        checks++;
        if ({psel, penable, pwrite, rsp_valid} !== 4'b1100) begin
            $display("FAIL read_access: got psel=%b pen=%b pwr=%b rv=%b, need 1 1 0 0", psel, penable, pwrite, rsp_valid);
        end else passes++;
        step();
        checks++;
        if ({rsp_valid, rsp_timeout, rsp_rdata, psel} !== {2'b10, 8'hA5, 1'b0}) begin
            $display("FAIL read_rsp: got rv=%b rto=%b rdata=%h psel=%b, need 1 0 a5 0", rsp_valid, rsp_timeout, rsp_rdata, psel);
        end else passes++;
        prdata = 8'h00;
        step();
        checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b0, 8'hA5}) begin
            $display("FAIL read_rdata_hold: got rv=%b rdata=%h, need 0 a5", rsp_valid, rsp_rdata);
        end else passes++;
    endtask

    task automatic test_wait_states();
        tie_psel   = 1'b0;
        pready_man = 1'b0;
        send_cmd(1'b1, COMMAND, 8'h80);
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({psel, penable, rsp_valid, paddr, pwdata} !== {3'b110, 8'h04, 8'h80}) begin
                $display("FAIL wait_access[%0d]: got psel=%b pen=%b rv=%b paddr=%h pwdata=%h, need 1 1 0 04 80",
                         k, psel, penable, rsp_valid, paddr, pwdata);
            end else passes++;
            if (k == 3) pready_man = 1'b1;
        end
        step();
        pready_man = 1'b0;
        checks++;
        if ({rsp_valid, rsp_timeout, rsp_rdata, psel, penable} !== {2'b10, 8'h00, 2'b00}) begin
            $display("FAIL wait_rsp: got rv=%b rto=%b rdata=%h psel=%b pen=%b, need 1 0 00 0 0",
                     rsp_valid, rsp_timeout, rsp_rdata, psel, penable);
        end else passes++;
        step();
    endtask

    task automatic test_timeout();
        int early;
        early      = 0;
        tie_psel   = 1'b0;
        pready_man = 1'b0;
        prdata     = 8'h5A;
        send_cmd(1'b0, RX_DATA, 8'h00);
        for (int k = 0; k < 16; k++) begin
            step();
            if (!(psel && penable) || rsp_valid) early++;
        end
        checks++;
        if (early !== 0) begin
            $display("FAIL timeout_hold: got %0d of 16 ACCESS cycles without psel/penable or with rsp_valid, need 0", early);
        end else passes++;
        step();
        checks++;
        if ({psel, penable, rsp_valid, rsp_timeout, rsp_rdata, cmd_ready} !== {4'b0011, 8'h00, 1'b1}) begin
            $display("FAIL timeout_rsp: got psel=%b pen=%b rv=%b rto=%b rdata=%h ready=%b, need 0 0 1 1 00 1",
                     psel, penable, rsp_valid, rsp_timeout, rsp_rdata, cmd_ready);
        end else passes++;
        step();
        checks++;
        if ({rsp_valid, rsp_timeout} !== 2'b01) begin
            $display("FAIL timeout_flag_hold: got rv=%b rto=%b, need 0 1", rsp_valid, rsp_timeout);
        end else passes++;
        tie_psel = 1'b1;
        send_cmd(1'b1, SLAVE_ADDR, 8'h42);
        step();
        step();
        checks++;
        if ({rsp_valid, rsp_timeout, paddr, pwdata} !== {2'b10, 8'h03, 8'h42}) begin
            $display("FAIL after_timeout_rsp: got rv=%b rto=%b paddr=%h pwdata=%h, need 1 0 03 42",
                     rsp_valid, rsp_timeout, paddr, pwdata);
        end else passes++;
        prdata = 8'h00;
        step();
    endtask

    task automatic test_back_to_back();
        tie_psel  = 1'b1;
        prdata    = 8'hC3;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = TRANSMIT;
        cmd_wdata = 8'h3C;
        step();
        cmd_write = 1'b0;
        cmd_addr  = RX_DATA;
        cmd_wdata = 8'hEE;
        checks++;
        if ({cmd_ready, psel, penable, pwrite, paddr, pwdata} !== {4'b0101, 8'h00, 8'h3C}) begin
            $display("FAIL b2b_setup1: got ready=%b psel=%b pen=%b pwr=%b paddr=%h pwdata=%h, need 0 1 0 1 00 3c",
                     cmd_ready, psel, penable, pwrite, paddr, pwdata);
        end else passes++;
        step();
        checks++;
        if ({cmd_ready, penable, pwrite, paddr} !== {3'b011, 8'h00}) begin
            $display("FAIL b2b_access1: got ready=%b pen=%b pwr=%b paddr=%h, need 0 1 1 00", cmd_ready, penable, pwrite, paddr);
        end else passes++;
        step();
        checks++;
        if ({rsp_valid, rsp_rdata, cmd_ready, psel} !== {1'b1, 8'h00, 2'b10}) begin
            $display("FAIL b2b_rsp1: got rv=%b rdata=%h ready=%b psel=%b, need 1 00 1 0", rsp_valid, rsp_rdata, cmd_ready, psel);
        end else passes++;
        step();
        cmd_valid = 1'b0;
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata, rsp_valid} !== {3'b100, 8'h01, 8'h3C, 1'b0}) begin
            $display("FAIL b2b_setup2: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b, need 1 0 0 01 3c 0",
                     psel, penable, pwrite, paddr, pwdata, rsp_valid);
        end else passes++;
        step();
        step();
        checks++;
        if ({rsp_valid, rsp_rdata, psel} !== {1'b1, 8'hC3, 1'b0}) begin
            $display("FAIL b2b_rsp2: got rv=%b rdata=%h psel=%b, need 1 c3 0", rsp_valid, rsp_rdata, psel);
        end else passes++;
        step();
        checks++;
        if ({psel, rsp_valid, cmd_ready} !== 3'b001) begin
            $display("FAIL b2b_no_extra: got psel=%b rv=%b ready=%b, need 0 0 1", psel, rsp_valid, cmd_ready);
        end else passes++;
        prdata = 8'h00;
    endtask

    task automatic test_reset_mid();
        tie_psel   = 1'b0;
        pready_man = 1'b0;
        prdata     = 8'h99;
        send_cmd(1'b0, STATUS, 8'h00);
        step();
        #2;
        preset_n = 1'b0;
        #1;
        checks++;
        if ({psel, penable, busy, rsp_valid} !== 4'b0000) begin
            $display("FAIL reset_mid_async: got psel=%b pen=%b busy=%b rv=%b, need 0 0 0 0", psel, penable, busy, rsp_valid);
        end else passes++;
        pready_man = 1'b1;
        step();
        checks++;
        if ({psel, rsp_valid, cmd_ready} !== 3'b001) begin
            $display("FAIL reset_mid_hold: got psel=%b rv=%b ready=%b, need 0 0 1", psel, rsp_valid, cmd_ready);
        end else passes++;
        preset_n   = 1'b1;
        pready_man = 1'b0;
        step();
        checks++;
        if ({cmd_ready, rsp_valid, psel} !== 3'b100) begin
            $display("FAIL reset_mid_release: got ready=%b rv=%b psel=%b, need 1 0 0", cmd_ready, rsp_valid, psel);
        end else passes++;
        tie_psel = 1'b1;
        send_cmd(1'b0, STATUS, 8'h00);
        step();
        step();
        checks++;
        if ({rsp_valid, rsp_timeout, rsp_rdata} !== {2'b10, 8'h99}) begin
            $display("FAIL reset_mid_fresh: got rv=%b rto=%b rdata=%h, need 1 0 99", rsp_valid, rsp_timeout, rsp_rdata);
        end else passes++;
        step();
    endtask

    initial begin
        preset_n   = 1'b0;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        prdata     = '0;
        tie_psel   = 1'b0;
        pready_man = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/apb_master_interface.md
Name: apb_master_interface

Overview:
- APB requester (initiator) that drives the I2C master's APB register interface (register map 0x00–0x05) from a simple valid/ready command port.
- Used by the on-chip test sequencer and firmware-bridge logic to program prescale, slave address and command, push TX bytes and poll status and RX data.
- Converts each accepted command into one APB SETUP→ACCESS transfer and returns a one-cycle response pulse.
- Bounds slave wait states with a programmable timeout.

Parameters:
- DATA_WIDTH, 8, width of pwdata/prdata and command/response data.
- ADDR_WIDTH, 8, width of paddr and command address.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- pclk_i  in  1  clock; all logic on rising edge.
- preset_ni  in  1  asynchronous reset, active-LOW.
- cmd_valid_i  in  1  command request.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  target register address.
- cmd_wdata_i  in  DATA_WIDTH  write data (ignored on reads).
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- rsp_valid_o  out  1  one-cycle pulse: transfer finished.
- rsp_rdata_o  out  DATA_WIDTH  read data captured; 0 for writes and timeouts.
- rsp_timeout_o  out  1  qualifies rsp_valid_o: transfer aborted by timeout.
- busy_o  out  1  high in SETUP or ACCESS.
- paddr_o  out  ADDR_WIDTH  APB address.
- pwrite_o  out  1  APB direction.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwdata_o  out  DATA_WIDTH  APB write data.
- prdata_i  in  DATA_WIDTH  APB read data.
- pready_i  in  1  APB ready.

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0 except cmd_ready_o = 1; timeout counter 0.
- Reset mid-transfer: psel_o/penable_o drop immediately; no response is issued.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE:
  - cmd_ready_o = 1 (decoded from state).
  - On a cmd_valid_i edge, latch addr, write and wdata into paddr_o/pwrite_o/pwdata_o.
  - Set psel_o = 1 and go to SETUP.
  - pwdata_o is loaded only for writes; reads leave it at its previous value.
- SETUP (exactly 1 cycle): psel_o = 1, penable_o = 0. Next edge: penable_o = 1, go to ACCESS.
- ACCESS: psel_o = 1, penable_o = 1. paddr_o/pwrite_o/pwdata_o stay stable from SETUP through the end of ACCESS.
- ACCESS completes on the first edge with pready_i = 1:
  - For reads, capture prdata_i into rsp_rdata_o; for writes, load 0.
  - Next cycle: rsp_valid_o = 1, rsp_timeout_o = 0, psel_o = penable_o = 0, state IDLE.
- Minimum latency: accept edge N → SETUP in cycle N+1 → ACCESS in N+2 → rsp_valid_o in N+3, where cmd_ready_o is high again.
- Back-to-back commands therefore have a 3-cycle throughput.
- Commands presented while cmd_ready_o = 0 are ignored; the command source must hold them stable.
- Wait states: the counter increments on every ACCESS edge with pready_i = 0 and clears on entering SETUP.
- Timeout: if TIMEOUT_CYCLES > 0 and the counter reaches TIMEOUT_CYCLES with pready_i still 0:
  - Abort: psel_o = penable_o = 0 and state IDLE.
  - rsp_valid_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0.
  - A pready_i arriving on the same edge as the limit counts as completion, not timeout.
- Counter width: max(1, $clog2(TIMEOUT_CYCLES+1)); it saturates and never wraps.
- rsp_rdata_o and rsp_timeout_o hold until the next response. rsp_valid_o is high for exactly one cycle.
- busy_o = psel_o.
- paddr_o/pwrite_o hold their last values in IDLE (no toggling).

Decomposition:
- Shared package i2c_apb_pkg:
  - FSM state localparams: IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10.
  - Register address constants: TRANSMIT 0x00, RX_DATA 0x01, STATUS 0x02, SLAVE_ADDR 0x03, COMMAND 0x04, PRESCALE 0x05.
  - The I2C master slave interface also uses these constants.
- Single module; no sub-module. The timeout counter stays inline.

Test Plan:
- Write 0x05 ← 0x1F, pready tied to psel:
  - SETUP at N+1 with paddr = 0x05, pwdata = 0x1F, pwrite = 1.
  - ACCESS at N+2.
  - rsp_valid at N+3 with rsp_rdata = 0, rsp_timeout = 0.
- Read 0x02, slave returns prdata = 0xA5 during ACCESS → rsp_rdata = 0xA5 with rsp_valid at N+3; pwrite = 0 throughout.
- Write 0x04 ← 0x80 with pready low for 3 ACCESS cycles:
  - penable stays high for 4 cycles; paddr and pwdata stay stable.
  - rsp_valid at N+6.
- TIMEOUT_CYCLES = 16, pready stuck low:
  - After 16 ACCESS cycles, psel/penable drop.
  - rsp_valid = 1, rsp_timeout = 1, rsp_rdata = 0.
  - The next command is accepted normally.
- cmd_valid held high with two queued commands (write 0x00 ← 0x3C, then read 0x01):
  - cmd_ready is low during SETUP/ACCESS; the second command is accepted only at the N+3 edge.
  - No APB cycle is merged or lost.
- preset_ni asserted during ACCESS of a read:
  - psel/penable go to 0 asynchronously; no rsp_valid pulse.
  - After release, cmd_ready = 1 and a fresh transfer completes normally.
